regfile_scb: RTL and testbench

REGFILE_SCB -- requirements
Module: regfile_scb

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_rdport.sv | 47 ++++
 rtl/regfile_scb.sv | 99 +++++++++
 tb/tb_regfile_scb.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - default sizing constants shared by the register file and its read ports
package regfile_pkg;

  localparam int WIDTH_D = 64;
  localparam int NREGS_D = 32;
  localparam int XZR_IDX = 31;

  // Value a register takes at reset; the zero register always holds zero.
  function automatic int unsigned reset_index(input int idx, input int zero_reg, input int init_index);
    if (idx == zero_reg || init_index == 0) begin
      return 0;
    end
    return idx;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one combinational read port: zero-reg mask, write forwarding, busy lookup
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int WIDTH    = WIDTH_D,
  parameter int NREGS    = NREGS_D,
  parameter int ZERO_REG = NREGS - 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic [AW-1:0]    ra,
  input  logic [WIDTH-1:0] regs [NREGS],
  input  logic [NREGS-1:0] busy_vec,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic             we4,
  input  logic [AW-1:0]    wa4,
  input  logic [WIDTH-1:0] wd4,
  output logic [WIDTH-1:0] rd,
  output logic             busy
);

  logic is_zero;

  assign is_zero = (ra == AW'(ZERO_REG));

  always_comb begin
    rd = regs[ra];
    // Port B is applied last so it wins when both ports hit the read address.
    if (BYPASS != 0) begin
      if (we3 && (wa3 == ra)) begin
        rd = wd3;
      end
      if (we4 && (wa4 == ra)) begin
        rd = wd4;
      end
    end
    if (is_zero) begin
      rd = '0;
    end
  end

  // The busy bit reflects stored state only; a same-cycle write does not clear it early.
  assign busy = busy_vec[ra] & ~is_zero;

endmodule

// File: rtl/regfile_scb.sv
// rtl/regfile_scb.sv - two-write/two-read register file with per-register pending-producer scoreboard
module regfile_scb
  import regfile_pkg::*;
#(
  parameter int WIDTH      = WIDTH_D,
  parameter int NREGS      = NREGS_D,
  parameter int ZERO_REG   = NREGS - 1,
  parameter int BYPASS     = 1,
  parameter int INIT_INDEX = 1,
  localparam int AW        = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic             we4,
  input  logic [AW-1:0]    wa4,
  input  logic [WIDTH-1:0] wd4,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             busy_set,
  input  logic [AW-1:0]    busy_wa,
  output logic             busy1,
  output logic             busy2
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] busy_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= WIDTH'(reset_index(i, ZERO_REG, INIT_INDEX));
      end
      busy_vec <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (i == ZERO_REG) begin
          regs[i]     <= '0;
          busy_vec[i] <= 1'b0;
        end else begin
          if (we4 && (wa4 == AW'(i))) begin
            regs[i] <= wd4;
          end else if (we3 && (wa3 == AW'(i))) begin
            regs[i] <= wd3;
          end
          // A new producer claimed in the same cycle outranks the retiring write.
          if (busy_set && (busy_wa == AW'(i))) begin
            busy_vec[i] <= 1'b1;
          end else if ((we4 && (wa4 == AW'(i))) || (we3 && (wa3 == AW'(i)))) begin
            busy_vec[i] <= 1'b0;
          end
        end
      end
    end
  end

  regfile_rdport #(
    .WIDTH    (WIDTH),
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_rdport1 (
    .ra       (ra1),
    .regs     (regs),
    .busy_vec (busy_vec),
    .we3      (we3),
    .wa3      (wa3),
    .wd3      (wd3),
    .we4      (we4),
    .wa4      (wa4),
    .wd4      (wd4),
    .rd       (rd1),
    .busy     (busy1)
  );

  regfile_rdport #(
    .WIDTH    (WIDTH),
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_rdport2 (
    .ra       (ra2),
    .regs     (regs),
    .busy_vec (busy_vec),
    .we3      (we3),
    .wa3      (wa3),
    .wd3      (wd3),
    .we4      (we4),
    .wa4      (wa4),
    .wd4      (wd4),
    .rd       (rd2),
    .busy     (busy2)
  );

endmodule

// File: tb/tb_regfile_scb.sv
// tb/tb_regfile_scb.sv - directed vector bench for regfile_scb, forwarding and stored-read variants side by side
module tb_regfile_scb;

  logic        clk = 1'b0;
  logic        reset;
  logic        we3, we4, busy_set;
  logic [4:0]  wa3, wa4, ra1, ra2, busy_wa;
  logic [63:0] wd3, wd4;
  logic [63:0] rd1, rd2, nrd1, nrd2;
  logic        busy1, busy2, nbusy1, nbusy2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_scb u_dut (
    .clk(clk), .reset(reset),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .we4(we4), .wa4(wa4), .wd4(wd4),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy_set(busy_set), .busy_wa(busy_wa),
    .busy1(busy1), .busy2(busy2)
  );

  regfile_scb #(.BYPASS(0)) u_dut_nb (
    .clk(clk), .reset(reset),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .we4(we4), .wa4(wa4), .wd4(wd4),
    .ra1(ra1), .ra2(ra2), .rd1(nrd1), .rd2(nrd2),
    .busy_set(busy_set), .busy_wa(busy_wa),
    .busy1(nbusy1), .busy2(nbusy2)
  );

  typedef struct {
    logic        rst;
    logic        we3;
    logic [4:0]  wa3;
    logic [63:0] wd3;
    logic        we4;
    logic [4:0]  wa4;
    logic [63:0] wd4;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        bs;
    logic [4:0]  bwa;
    logic [63:0] e_rd1;
    logic [63:0] e_rd2;
    logic        e_b1;
    logic        e_b2;
    logic [63:0] n_rd1;
    logic [63:0] n_rd2;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=0x%h expected=0x%h", name, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    reset = 1'b0; we3 = 1'b0; we4 = 1'b0; busy_set = 1'b0;
    wa3 = '0; wa4 = '0; wd3 = '0; wd4 = '0; busy_wa = '0;
  endtask

  initial begin
    // Inputs are driven just after the falling edge and outputs are checked 1ns later,
    // so each record's expectations describe the cycle before its rising edge.
    //            rst we3 wa3 wd3                     we4 wa4 wd4       ra1 ra2 bs bwa  e_rd1     e_rd2     b1 b2  n_rd1     n_rd2
    vecs[0]  = '{0, 1, 4,  64'hFFF,                0, 0,  64'h0,     4,  4,  0, 0,  64'hFFF,  64'hFFF,  0, 0,  64'h4,    64'h4};
    vecs[1]  = '{0, 0, 0,  64'h0,                  0, 0,  64'h0,     4,  0,  0, 0,  64'hFFF,  64'h0,    0, 0,  64'hFFF,  64'h0};
    vecs[2]  = '{0, 1, 7,  64'hAAAA,               1, 7,  64'h5555,  7,  3,  0, 0,  64'h5555, 64'h3,    0, 0,  64'h7,    64'h3};
    vecs[3]  = '{0, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0,  64'h0,     31, 7,  0, 0,  64'h0,    64'h5555, 0, 0,  64'h0,    64'h5555};
    vecs[4]  = '{0, 0, 0,  64'h0,                  0, 0,  64'h0,     31, 7,  0, 0,  64'h0,    64'h5555, 0, 0,  64'h0,    64'h5555};
    vecs[5]  = '{0, 0, 0,  64'h0,                  0, 0,  64'h0,     9,  31, 1, 9,  64'h9,    64'h0,    0, 0,  64'h9,    64'h0};
    vecs[6]  = '{0, 0, 0,  64'h0,                  0, 0,  64'h0,     9,  9,  0, 0,  64'h9,    64'h9,    1, 1,  64'h9,    64'h9};
    vecs[7]  = '{0, 0, 0,  64'h0,                  1, 9,  64'h9,     9,  31, 0, 0,  64'h9,    64'h0,    1, 0,  64'h9,    64'h0};
    vecs[8]  = '{0, 0, 0,  64'h0,                  0, 0,  64'h0,     9,  9,  0, 0,  64'h9,    64'h9,    0, 0,  64'h9,    64'h9};
    vecs[9]  = '{0, 1, 9,  64'h99,                 0, 0,  64'h0,     9,  2,  1, 9,  64'h99,   64'h2,    0, 0,  64'h9,    64'h2};
    vecs[10] = '{0, 0, 0,  64'h0,                  0, 0,  64'h0,     9,  2,  0, 0,  64'h99,   64'h2,    1, 0,  64'h99,   64'h2};
    vecs[11] = '{0, 0, 0,  64'h0,                  0, 0,  64'h0,     31, 9,  1, 31, 64'h0,    64'h99,   0, 1,  64'h0,    64'h99};
    vecs[12] = '{0, 0, 0,  64'h0,                  0, 0,  64'h0,     31, 9,  0, 0,  64'h0,    64'h99,   0, 1,  64'h0,    64'h99};
    vecs[13] = '{0, 0, 5,  64'h1234_5678_9ABC_DEF0, 0, 0,  64'h0,     5,  6,  0, 0,  64'h5,    64'h6,    0, 0,  64'h5,    64'h6};
    vecs[14] = '{0, 0, 0,  64'h0,                  0, 0,  64'h0,     5,  6,  0, 0,  64'h5,    64'h6,    0, 0,  64'h5,    64'h6};
    vecs[15] = '{0, 1, 10, 64'hA0,                 1, 11, 64'hB0,    10, 11, 0, 0,  64'hA0,   64'hB0,   0, 0,  64'hA,    64'hB};
    vecs[16] = '{0, 0, 0,  64'h0,                  0, 0,  64'h0,     10, 11, 1, 6,  64'hA0,   64'hB0,   0, 0,  64'hA0,   64'hB0};
    vecs[17] = '{1, 1, 5,  64'h123,                0, 0,  64'h0,     5,  6,  1, 6,  64'h123,  64'h6,    0, 1,  64'h5,    64'h6};
    vecs[18] = '{0, 0, 0,  64'h0,                  0, 0,  64'h0,     5,  6,  0, 0,  64'h5,    64'h6,    0, 0,  64'h5,    64'h6};
    vecs[19] = '{0, 0, 0,  64'h0,                  0, 0,  64'h0,     9,  7,  0, 0,  64'h9,    64'h7,    0, 0,  64'h9,    64'h7};
    vecs[20] = '{0, 0, 0,  64'h0,                  0, 0,  64'h0,     4,  10, 0, 0,  64'h4,    64'hA,    0, 0,  64'h4,    64'hA};
    vecs[21] = '{0, 0, 0,  64'h0,                  0, 0,  64'h0,     11, 31, 0, 0,  64'hB,    64'h0,    0, 0,  64'hB,    64'h0};

    drive_idle();
    reset = 1'b1;
    ra1 = '0;
    ra2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ra1 = 5'(i);
      ra2 = 5'(i);
      #1;
      check("sweep_rd1",   i, rd1,  (i < 31) ? 64'(i) : 64'h0);
      check("sweep_rd2",   i, rd2,  (i < 31) ? 64'(i) : 64'h0);
      check("sweep_busy1", i, 64'(busy1), 64'h0);
      check("sweep_busy2", i, 64'(busy2), 64'h0);
      check("sweep_nb_rd1", i, nrd1, (i < 31) ? 64'(i) : 64'h0);
    end

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      reset    = vecs[k].rst;
      we3      = vecs[k].we3;
      wa3      = vecs[k].wa3;
      wd3      = vecs[k].wd3;
      we4      = vecs[k].we4;
      wa4      = vecs[k].wa4;
      wd4      = vecs[k].wd4;
      ra1      = vecs[k].ra1;
      ra2      = vecs[k].ra2;
      busy_set = vecs[k].bs;
      busy_wa  = vecs[k].bwa;
      #1;
      check("rd1",    k, rd1,  vecs[k].e_rd1);
      check("rd2",    k, rd2,  vecs[k].e_rd2);
      check("busy1",  k, 64'(busy1), 64'(vecs[k].e_b1));
      check("busy2",  k, 64'(busy2), 64'(vecs[k].e_b2));
      check("nb_rd1", k, nrd1, vecs[k].n_rd1);
      check("nb_rd2", k, nrd2, vecs[k].n_rd2);
      check("nb_busy1", k, 64'(nbusy1), 64'(vecs[k].e_b1));
    end

    // Reset held across several cycles while writes and busy_set keep firing.
    @(negedge clk);
    drive_idle();
    reset = 1'b1; we4 = 1'b1; wa4 = 5'd3; wd4 = 64'hDEAD; busy_set = 1'b1; busy_wa = 5'd3;
    ra1 = 5'd3; ra2 = 5'd3;
    repeat (2) @(negedge clk);
    drive_idle();
    #1;
    check("hold_reset_rd1",   100, rd1,  64'h3);
    check("hold_reset_busy1", 100, 64'(busy1), 64'h0);
    check("hold_reset_nb_rd2", 100, nrd2, 64'h3);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
